// File: rtl/uart_rx_parity_bit.sv
// uart_rx_parity_bit: 8-bit UART receiver with optional odd/even parity check.
// Samples the synchronized line at mid-bit and reports each frame with a valid strobe and error flags.
module uart_rx_parity_bit #(
   parameter int BAUDRATE       = 115_200,
   parameter int BASE_CLK       = 50_000_000,
   parameter int CLOCKS_PER_BIT = BASE_CLK / BAUDRATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       input_data_serial,
   input  logic [1:0] parity_type,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       framing_error,
   output logic       rx_busy
);
   localparam logic [31:0] FULL_LIM = 32'(CLOCKS_PER_BIT - 1);
   localparam logic [31:0] HALF_LIM = 32'(CLOCKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_sync1, r_sync2, r_prev;
   logic [31:0] r_cnt, w_cnt_nxt;
   logic [2:0]  r_idx, w_idx_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic [1:0]  r_ptype, w_ptype_nxt;
   logic        r_perr, w_perr_nxt;
   logic        w_load;
   logic        w_fall;
   logic        w_exp_par;

   assign w_fall    = r_prev & ~r_sync2;
   assign w_exp_par = (r_ptype == 2'd1) ? ~^r_shift : ^r_shift;
   assign rx_busy   = (r_state != RX_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 32'd1;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_ptype_nxt = r_ptype;
      w_perr_nxt  = r_perr;
      w_load      = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_nxt = '0;
            if (w_fall) begin
               w_ptype_nxt = (parity_type == 2'd3) ? 2'd0 : parity_type;
               w_idx_nxt   = '0;
               w_perr_nxt  = 1'b0;
               w_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (r_cnt >= HALF_LIM) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_cnt >= FULL_LIM) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = r_sync2;
               w_idx_nxt          = r_idx + 3'd1;
               if (r_idx == 3'd7)
                  w_state_nxt = (r_ptype != 2'd0) ? RX_PARITY : RX_STOP;
            end
         end
         RX_PARITY: begin
            if (r_cnt >= FULL_LIM) begin
               w_cnt_nxt   = '0;
               w_perr_nxt  = (r_sync2 != w_exp_par);
               w_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            // Leave at mid-stop so a start bit right after the stop bit is caught.
            if (r_cnt >= FULL_LIM) begin
               w_cnt_nxt   = '0;
               w_load      = 1'b1;
               w_state_nxt = RX_IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= RX_IDLE;
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_prev        <= 1'b1;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shift       <= '0;
         r_ptype       <= '0;
         r_perr        <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         r_sync1  <= input_data_serial;
         r_sync2  <= r_sync1;
         r_prev   <= r_sync2;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_shift  <= w_shift_nxt;
         r_ptype  <= w_ptype_nxt;
         r_perr   <= w_perr_nxt;
         rx_valid <= w_load;
         if (w_load) begin
            rx_data       <= r_shift;
            parity_error  <= r_perr;
            framing_error <= ~r_sync2;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_parity_bit.sv
// tb_uart_rx_parity_bit: directed frames at 16 clocks per bit with hand-computed expectations.
module tb_uart_rx_parity_bit;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser = 1'b1;
   logic [1:0] ptype = 2'd0;
   logic [7:0] rx_data;
   logic       rx_valid, parity_error, framing_error, rx_busy;

   int         n_assert = 0;
   int         n_fail = 0;
   int         n_valid = 0;
   int         v0;
   logic [7:0] cap_prev = 8'h00;
   logic [7:0] cap_last = 8'h00;
   logic [7:0] d;

   uart_rx_parity_bit #(.CLOCKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .input_data_serial(ser),
      .parity_type(ptype),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .parity_error(parity_error),
      .framing_error(framing_error),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (rx_valid) begin
         n_valid++;
         cap_prev = cap_last;
         cap_last = rx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ser = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      ser = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] data, input logic pe, input logic pb, input logic sb);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      if (pe) send_bit(pb);
      send_bit(sb);
   endtask

   initial begin
      #3 rst = 1'b0;
      #1;
      check("reset rx_data", rx_data, 8'h00);
      check("reset rx_valid", rx_valid, 1'b0);
      check("reset parity_error", parity_error, 1'b0);
      check("reset framing_error", framing_error, 1'b0);
      check("reset rx_busy", rx_busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      ptype = 2'd0; idle(32); v0 = n_valid;
      frame(8'hA5, 1'b0, 1'b0, 1'b1); idle(4);
      check("A5 pulses", n_valid - v0, 1);
      check("A5 data", rx_data, 8'hA5);
      check("A5 perr", parity_error, 1'b0);
      check("A5 ferr", framing_error, 1'b0);
      check("A5 busy after", rx_busy, 1'b0);

      ptype = 2'd2; idle(32); v0 = n_valid;
      frame(8'h3C, 1'b1, 1'b0, 1'b1); idle(4);
      check("even ok pulses", n_valid - v0, 1);
      check("even ok data", rx_data, 8'h3C);
      check("even ok perr", parity_error, 1'b0);
      idle(32); v0 = n_valid;
      frame(8'h3C, 1'b1, 1'b1, 1'b1); idle(4);
      check("even bad pulses", n_valid - v0, 1);
      check("even bad perr", parity_error, 1'b1);
      check("even bad ferr", framing_error, 1'b0);

      ptype = 2'd1; idle(32); v0 = n_valid;
      frame(8'h01, 1'b1, 1'b0, 1'b1); idle(4);
      check("odd pulses", n_valid - v0, 1);
      check("odd data", rx_data, 8'h01);
      check("odd perr", parity_error, 1'b0);

      ptype = 2'd3; idle(32); v0 = n_valid;
      frame(8'h7E, 1'b0, 1'b0, 1'b1); idle(4);
      check("ptype3 pulses", n_valid - v0, 1);
      check("ptype3 data", rx_data, 8'h7E);
      check("ptype3 perr", parity_error, 1'b0);

      ptype = 2'd0; idle(32); v0 = n_valid;
      frame(8'h55, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("ferr pulses", n_valid - v0, 1);
      check("ferr data", rx_data, 8'h55);
      check("ferr flag", framing_error, 1'b1);
      v0 = n_valid;
      repeat (3 * CPB) @(negedge clk);
      check("held low no frame", n_valid - v0, 0);
      check("held low busy", rx_busy, 1'b0);
      idle(32);
      frame(8'h12, 1'b0, 1'b0, 1'b1); idle(4);
      check("after low pulses", n_valid - v0, 1);
      check("after low data", rx_data, 8'h12);
      check("after low ferr", framing_error, 1'b0);

      idle(32); v0 = n_valid;
      ser = 1'b0; repeat (5) @(negedge clk);
      idle(40);
      check("glitch pulses", n_valid - v0, 0);
      check("glitch busy", rx_busy, 1'b0);
      check("glitch data held", rx_data, 8'h12);

      frame(8'hC3, 1'b0, 1'b0, 1'b1);
      frame(8'h81, 1'b0, 1'b0, 1'b1); idle(4);
      check("b2b pulses", n_valid - v0, 2);
      check("b2b first", cap_prev, 8'hC3);
      check("b2b second", cap_last, 8'h81);

      idle(32); v0 = n_valid;
      d = 8'h99;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      ser = d[4];
      repeat (5) @(negedge clk);
      check("busy mid frame", rx_busy, 1'b1);
      rst = 1'b0;
      #1;
      check("midrst rx_data", rx_data, 8'h00);
      check("midrst rx_valid", rx_valid, 1'b0);
      check("midrst ferr", framing_error, 1'b0);
      check("midrst busy", rx_busy, 1'b0);
      ser = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      idle(32);
      check("midrst no pulse", n_valid - v0, 0);
      frame(8'h99, 1'b0, 1'b0, 1'b1); idle(4);
      check("99 pulses", n_valid - v0, 1);
      check("99 data", rx_data, 8'h99);
      check("99 ferr", framing_error, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_parity_bit.md
Name: uart_rx_parity_bit

Overview:
- UART receiver with optional parity check; the downstream peer of uart_tx_parity_bit on the serial link.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Oversamples the asynchronous serial line on the system clock and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
BAUDRATE, 115_200, serial bit rate.
BASE_CLK, 50_000_000, clk frequency in Hz.
CLOCKS_PER_BIT, BASE_CLK/BAUDRATE (434), clk cycles per bit; may be overridden directly for simulation.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
input_data_serial  input  1  asynchronous serial line; idles high.
parity_type  input  2  0 = no parity, 1 = odd, 2 = even, 3 = treated as no parity.
rx_data  output  8  last received byte.
rx_valid  output  1  one-cycle strobe: frame complete, rx_data and error flags updated.
parity_error  output  1  parity mismatch on the last frame.
framing_error  output  1  stop bit sampled 0 on the last frame.
rx_busy  output  1  high in every state except RX_IDLE.

Behaviour:
- Reset (rst = 0, async):
  - State goes to RX_IDLE; counters clear.
  - rx_data = 0; rx_valid, parity_error, framing_error, rx_busy = 0.
  - Both synchronizer flops and the edge-detect register reset to 1.
  - Reset mid-frame abandons the frame with no rx_valid.
- Input synchronization: 2-flop synchronizer on input_data_serial. All decisions use the synchronized line. This adds 2 cycles of latency.
- RX_IDLE:
  - Wait for a falling edge on the synced line (previous 1, current 0). A line held low never retriggers.
  - On the edge: latch parity_type (3 maps to 0), clear the bit counter, go to RX_START.
- RX_START:
  - Count CLOCKS_PER_BIT/2 − 1 cycles, then sample.
  - Sample 0: clear the counter, go to RX_DATA.
  - Sample 1: glitch / false start; return to RX_IDLE with no outputs changed.
- RX_DATA:
  - Count CLOCKS_PER_BIT − 1 cycles, then sample into shift register bit [idx], idx = 0..7.
  - After bit 7: go to RX_PARITY if latched parity ≠ 0, else go to RX_STOP.
- RX_PARITY:
  - Wait one full bit and sample it.
  - Expected parity: odd = ~^data, even = ^data (identical to the transmitter).
  - Store mismatch internally.
- RX_STOP:
  - Wait one full bit and sample it.
  - On that clock edge, register all of the following:
    - rx_data ← shift register.
    - parity_error ← mismatch (0 when no parity).
    - framing_error ← ~stop_sample.
    - rx_valid ← 1 for exactly one cycle.
  - Go directly to RX_IDLE at mid-stop-bit, so back-to-back frames are accepted.
- Output holding:
  - Error flags and rx_data hold until the next completed frame.
  - rx_valid fires even when error flags are set; consumers qualify the byte with the flags.
- Counter: 32-bit unsigned; compare "< limit" and clear at each bit boundary. No wrap is possible.
- parity_type changes mid-frame are ignored (latched value is used).
- Latency: rx_valid rises 2 + (CLOCKS_PER_BIT/2) + N·CLOCKS_PER_BIT cycles (±1) after the start falling edge, where N = 9 without parity and N = 10 with parity.
- Unused state encodings return to RX_IDLE.

Test Plan (CLOCKS_PER_BIT = 16, ideal bit timing driven from the bench):
- parity_type=0, send 0xA5 with stop=1 -> exactly one rx_valid pulse, rx_data=0xA5, parity_error=0, framing_error=0, rx_busy low afterwards.
- parity_type=2 (even), send 0x3C with parity bit 0 -> rx_data=0x3C, no errors. Repeat with parity bit 1 -> parity_error=1, rx_valid still pulses.
- parity_type=1 (odd), send 0x01 with parity bit 0 -> no error. parity_type=3, send 0x7E with no parity bit -> received as no-parity frame, rx_data=0x7E.
- Send 0x55 with stop bit 0 -> rx_valid pulse, framing_error=1, rx_data=0x55. Then hold the line low for 3 bit times -> no new frame until the line returns high and falls again.
- Low glitch of 5 cycles (< 8) on an idle line -> no rx_valid, returns to idle. Then 0xC3, 0x81 sent back-to-back with 1 stop bit each -> two pulses, 0xC3 then 0x81.
- Assert rst=0 during data bit 4 -> all outputs 0 immediately, no rx_valid. Release and send 0x99 -> received correctly.
